// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Each access runs issue -> fixed-latency wait -> completion, round-robin on conflict.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0]        state;
  logic              owner;
  logic              last_ls;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        cnt;
  logic              pick_ls;
  logic              issue;
  logic              fin;

  // LS wins alone, or on a conflict when IF had the previous grant
  assign pick_ls = ls_req & (~if_req | ~last_ls);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last_ls   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req | ls_req) begin
            owner     <= pick_ls;
            last_ls   <= pick_ls;
            lat_we    <= pick_ls & ls_we;
            lat_addr  <= pick_ls ? ls_addr : if_addr;
            lat_wdata <= pick_ls ? ls_wdata : '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            state <= DONE;
          end else begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (owner) ls_rdata <= mem_rdata;
            else       if_rdata <= mem_rdata;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign issue     = (state == ISSUE);
  assign fin       = (state == DONE);
  assign if_gnt    = issue & ~owner;
  assign ls_gnt    = issue & owner;
  assign if_done   = fin & ~owner;
  assign ls_done   = fin & owner;
  assign mem_en    = issue;
  assign mem_we    = issue & lat_we;
  assign mem_addr  = issue ? lat_addr : '0;
  assign mem_wdata = issue ? lat_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_done(ls_done),
    .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    if (a == 32'h40) return 32'hCAFEF00D;
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // memory: read data valid only LAT cycles after a read strobe, junk otherwise
  logic [LAT:1] pv = '0;
  logic [31:0]  pa [1:LAT];
  logic [31:0]  junk = 32'h0;

  always @(posedge clk) begin
    pv    <= {pv[LAT-1:1], mem_en & ~mem_we};
    pa[1] <= mem_addr;
    for (int i = 2; i <= LAT; i++) pa[i] <= pa[i-1];
    junk  <= $urandom;
  end

  assign mem_rdata = pv[LAT] ? memf(pa[LAT]) : junk;

  // transaction-level model: one access scheduled by its grant and done cycles
  int          n = 0;
  int          tg = 0;
  int          td = 0;
  bit          armed = 0;
  bit          busy = 0;
  bit          own_ls = 0;
  bit          last_ls = 0;
  bit          m_we = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wd = 0;
  logic [31:0] m_rd = 0;
  logic [31:0] e_if_rd = 0;
  logic [31:0] e_ls_rd = 0;
  logic [133:0] act_v;
  logic [133:0] exp_v;
  bit          g_now;
  bit          d_now;

  always @(negedge clk) begin
    g_now = busy && (n == tg);
    d_now = busy && (n == td);
    if (d_now && !m_we) begin
      if (own_ls) e_ls_rd = m_rd;
      else        e_if_rd = m_rd;
    end
    exp_v = {g_now && !own_ls, d_now && !own_ls, e_if_rd,
             g_now && own_ls, d_now && own_ls, e_ls_rd,
             g_now, g_now && m_we,
             g_now ? m_addr : 32'h0, g_now ? m_wd : 32'h0};
    act_v = {if_gnt, if_done, if_rdata,
             ls_gnt, ls_done, ls_rdata,
             mem_en, mem_we, mem_addr, mem_wdata};
    if (armed) begin
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_%0d outputs got %h want %h",
                 n, act_v, exp_v);
      end
    end
    if (reset) begin
      armed   = 1;
      busy    = 0;
      last_ls = 0;
      e_if_rd = 0;
      e_ls_rd = 0;
    end else if (!busy || n > td) begin
      busy = 0;
      if (if_req || ls_req) begin
        own_ls  = ls_req && (!if_req || !last_ls);
        last_ls = own_ls;
        busy    = 1;
        m_we    = own_ls && ls_we;
        tg      = n + 1;
        td      = m_we ? n + 2 : n + 2 + LAT;
        m_addr  = own_ls ? ls_addr : if_addr;
        m_wd    = own_ls ? ls_wdata : 32'h0;
        m_rd    = memf(m_addr);
      end
    end
    n++;
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, a, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output bit gi, output bit gl, output int lat);
    gi = 0;
    gl = 0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) begin
        gi = if_gnt;
        gl = ls_gnt;
        return;
      end
      lat++;
    end
    checks++;
    errors++;
    $display("FAIL gnt_timeout got none want grant within 40");
  endtask

  bit gi, gl;
  int lat;

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // conflicts from reset: LS, IF, LS, IF
    if_req = 1; if_addr = 32'h10;
    ls_req = 1; ls_we = 0; ls_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(gi, gl, lat);
      chk1("arb_ls_turn", gl, k % 2 == 0);
      chk1("arb_if_turn", gi, k % 2 == 1);
      if (k == 0) chk("arb_first_lat", lat, 1);
      drv();
      if (gl) ls_req = 0;
      else    if_req = 0;
      drv();
      if (k < 3) begin
        if (gl) ls_req = 1;
        else    if_req = 1;
      end else begin
        if_req = 0;
        ls_req = 0;
      end
    end
    repeat (6) nxt();

    // IF fetch alone
    drv();
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk1("t1_gnt_c0", if_gnt, 0);
    nxt();
    chk1("t1_gnt", if_gnt, 1);
    chk1("t1_mem_en", mem_en, 1);
    chk("t1_addr", mem_addr, 32'h10);
    drv();
    if_req = 0;
    @(negedge clk);
    repeat (2) nxt();
    chk1("t1_done_c4", if_done, 0);
    nxt();
    chk1("t1_done", if_done, 1);
    chk("t1_rdata", if_rdata, 32'h00500093);

    // store
    drv();
    ls_req = 1; ls_we = 1;
    ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    nxt();
    chk1("t2_gnt", ls_gnt, 1);
    chk1("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 32'h200);
    chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
    drv();
    ls_req = 0; ls_we = 0;
    @(negedge clk);
    chk1("t2_done", ls_done, 1);
    chk("t2_rdata_kept", ls_rdata, 32'hCAFEF00D);
    nxt();
    chk1("t2_idle_en", mem_en, 0);

    // reset in the middle of a load wait
    drv();
    ls_req = 1; ls_addr = 32'h80;
    @(negedge clk);
    nxt();
    chk1("t5_gnt", ls_gnt, 1);
    drv();
    ls_req = 0;
    @(negedge clk);
    drv();
    reset = 1;
    @(negedge clk);
    drv();
    reset = 0;
    @(negedge clk);
    chk("t5_if_rdata", if_rdata, 32'h0);
    chk("t5_ls_rdata", ls_rdata, 32'h0);
    chk1("t5_en", mem_en, 0);
    for (int i = 0; i < 4; i++) begin
      chk1("t5_no_done", ls_done, 0);
      nxt();
    end
    drv();
    if_req = 1; if_addr = 32'h10;
    wait_gnt(gi, gl, lat);
    chk("t5_fresh_lat", lat, 1);
    drv();
    if_req = 0;
    @(negedge clk);
    repeat (3) nxt();
    chk1("t5_fresh_done", if_done, 1);
    chk("t5_fresh_rdata", if_rdata, 32'h00500093);

    // multi-cycle load with IF arriving during the wait
    drv();
    ls_req = 1; ls_we = 0; ls_addr = 32'h40;
    @(negedge clk);
    nxt();
    chk1("t4_gnt", ls_gnt, 1);
    drv();
    ls_req = 0;
    @(negedge clk);
    drv();
    if_req = 1; if_addr = 32'h20;
    @(negedge clk);
    chk1("t4_if_wait_c3", if_gnt, 0);
    nxt();
    chk1("t4_done_c4", ls_done, 0);
    chk("t4_rdata_c4", ls_rdata, 32'h0);
    nxt();
    chk1("t4_done", ls_done, 1);
    chk("t4_rdata", ls_rdata, 32'hCAFEF00D);
    nxt();
    chk1("t4_if_c6", if_gnt, 0);
    nxt();
    chk1("t4_if_c7", if_gnt, 1);
    drv();
    if_req = 0;
    repeat (6) nxt();

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gi = if_gnt;
      gl = ls_gnt;
      drv();
      reset = ($urandom_range(0, 299) == 0);
      if (reset) begin
        if_req = 0;
        ls_req = 0;
      end else begin
        if (gi) if_req = 0;
        else if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req  = 1;
          if_addr = 32'($urandom_range(0, 255)) << 2;
        end
        if (gl) ls_req = 0;
        else if (!ls_req && $urandom_range(0, 2) == 0) begin
          ls_req   = 1;
          ls_we    = 1'($urandom_range(0, 1));
          ls_addr  = 32'($urandom_range(0, 255)) << 2;
          ls_wdata = $urandom;
        end
      end
    end
    drv();
    reset = 0;
    if_req = 0;
    ls_req = 0;
    repeat (10) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
